// File: rtl/main_mem_pkg.sv
// Shared types and default geometry for the main memory responder.
package main_mem_pkg;

    localparam int DEF_LINE_ADDR_LEN = 3;
    localparam int DEF_MEM_ADDR_LEN  = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WAIT  = 2'd1,
        BURST = 2'd2
    } state_t;

    typedef enum logic {
        OP_READ  = 1'b0,
        OP_WRITE = 1'b1
    } op_t;

    function automatic int line_size(input int line_addr_len);
        return 1 << line_addr_len;
    endfunction

endpackage

// File: rtl/mem_word_array.sv
// Single-port 32-bit word RAM: synchronous write, combinational read.
module mem_word_array #(
    parameter int ADDR_W = 11
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [31:0]       wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [31:0]       rdata
);

    logic [31:0] mem [2**ADDR_W];

    // No reset: contents survive rst so a half-written line stays visible.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/main_mem_responder.sv
// Line-granular memory responder below the data cache; fixed latency then one word per cycle.
// Define MAIN_MEM_STATS_EN to add the rd_count / wr_count completion counters.
//
// state | meaning
// IDLE  | waiting for a request; write wins over read
// WAIT  | fixed access latency countdown on wait_cnt
// BURST | one word per cycle between the line register and the array
module main_mem_responder
    import main_mem_pkg::*;
#(
    parameter int LINE_ADDR_LEN = DEF_LINE_ADDR_LEN,
    parameter int MEM_ADDR_LEN  = DEF_MEM_ADDR_LEN,
    parameter int LATENCY       = 20
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               rd_req,
    input  logic                               wr_req,
    input  logic [MEM_ADDR_LEN-1:0]            addr,
    input  logic [32*(2**LINE_ADDR_LEN)-1:0]   wr_line,
    output logic [32*(2**LINE_ADDR_LEN)-1:0]   rd_line,
    output logic                               gnt
`ifdef MAIN_MEM_STATS_EN
    ,
    output logic [31:0]                        rd_count,
    output logic [31:0]                        wr_count
`endif
);

    localparam int LINE_SIZE = line_size(LINE_ADDR_LEN);
    localparam int WORD_AW   = MEM_ADDR_LEN + LINE_ADDR_LEN;
    localparam int WAIT_W    = $clog2(LATENCY) + 1;

    localparam logic [WAIT_W-1:0]        WAIT_INIT = WAIT_W'(LATENCY - 1);
    localparam logic [LINE_ADDR_LEN-1:0] LAST_IDX  = '1;

    state_t                         state;
    op_t                            op_q;
    logic [MEM_ADDR_LEN-1:0]        addr_q;
    logic [LINE_SIZE-1:0][31:0]     wr_line_q;
    logic [LINE_SIZE-1:0][31:0]     rd_line_q;
    logic [WAIT_W-1:0]              wait_cnt;
    logic [LINE_ADDR_LEN-1:0]       word_idx;

    logic                           mem_we;
    logic [WORD_AW-1:0]             word_addr;
    logic [31:0]                    mem_rdata;

    assign word_addr = {addr_q, word_idx};
    assign mem_we    = (state == BURST) && (op_q == OP_WRITE);
    assign rd_line   = rd_line_q;

    mem_word_array #(
        .ADDR_W (WORD_AW)
    ) u_array (
        .clk    (clk),
        .we     (mem_we),
        .waddr  (word_addr),
        .wdata  (wr_line_q[word_idx]),
        .raddr  (word_addr),
        .rdata  (mem_rdata)
    );

    always_ff @(posedge clk) begin
        if (!rst) begin
            state     <= IDLE;
            op_q      <= OP_READ;
            addr_q    <= '0;
            wr_line_q <= '0;
            rd_line_q <= '0;
            wait_cnt  <= '0;
            word_idx  <= '0;
            gnt       <= 1'b0;
`ifdef MAIN_MEM_STATS_EN
            rd_count  <= '0;
            wr_count  <= '0;
`endif
        end else begin
            gnt <= 1'b0;
            case (state)
                IDLE: begin
                    if (wr_req) begin
                        addr_q    <= addr;
                        wr_line_q <= wr_line;
                        op_q      <= OP_WRITE;
                        wait_cnt  <= WAIT_INIT;
                        state     <= WAIT;
                    end else if (rd_req) begin
                        addr_q   <= addr;
                        op_q     <= OP_READ;
                        wait_cnt <= WAIT_INIT;
                        state    <= WAIT;
                    end
                end
                WAIT: begin
                    if (wait_cnt == '0) begin
                        word_idx <= '0;
                        state    <= BURST;
                    end else begin
                        wait_cnt <= wait_cnt - 1'b1;
                    end
                end
                BURST: begin
                    if (op_q == OP_READ) begin
                        rd_line_q[word_idx] <= mem_rdata;
                    end
                    word_idx <= word_idx + 1'b1;
                    if (word_idx == LAST_IDX) begin
                        state <= IDLE;
                        gnt   <= 1'b1;
`ifdef MAIN_MEM_STATS_EN
                        if (op_q == OP_READ) begin
                            rd_count <= rd_count + 1'b1;
                        end else begin
                            wr_count <= wr_count + 1'b1;
                        end
`endif
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_main_mem_responder.sv
// Scoreboard bench for main_mem_responder: directed line reads/writes, priority, drop and reset cases.
module tb_main_mem_responder;

    localparam int LAL = 3;
    localparam int MAL = 8;
    localparam int LAT = 20;
    localparam int LS  = 8;
    localparam int LW  = 32 * LS;
    localparam int GNT_DELAY = LAT + LS + 1;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          rd_req = 1'b0;
    logic          wr_req = 1'b0;
    logic [MAL-1:0] addr = '0;
    logic [LW-1:0] wr_line = '0;
    logic [LW-1:0] rd_line;
    logic          gnt;
`ifdef MAIN_MEM_STATS_EN
    logic [31:0]   rd_count;
    logic [31:0]   wr_count;
`endif

    main_mem_responder #(
        .LINE_ADDR_LEN (LAL),
        .MEM_ADDR_LEN  (MAL),
        .LATENCY       (LAT)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .rd_req  (rd_req),
        .wr_req  (wr_req),
        .addr    (addr),
        .wr_line (wr_line),
        .rd_line (rd_line),
        .gnt     (gnt)
`ifdef MAIN_MEM_STATS_EN
        ,
        .rd_count (rd_count),
        .wr_count (wr_count)
`endif
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int            exp_cyc;
        logic          is_wr;
        logic          chk_data;
        logic [LW-1:0] data;
        int            tag;
    } exp_t;

    exp_t          sb[$];
    int            n_checks = 0;
    int            n_fail   = 0;
    logic [31:0]   ref_mem [2**(MAL+LAL)];
    logic [LW-1:0] last_rd  = '0;
    logic          rd_known = 1'b0;
    int            tag_seq  = 0;
    int            exp_rd_cnt = 0;
    int            exp_wr_cnt = 0;

    function automatic void check_int(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endfunction

    function automatic void check_line(input string name, input logic [LW-1:0] act, input logic [LW-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endfunction

    function automatic logic [LW-1:0] mk_line(input logic [31:0] base);
        logic [LW-1:0] l;
        for (int i = 0; i < LS; i++) l[32*i +: 32] = base + 32'(i);
        return l;
    endfunction

    function automatic logic [LW-1:0] ref_line(input int a);
        logic [LW-1:0] l;
        for (int i = 0; i < LS; i++) l[32*i +: 32] = ref_mem[a*LS + i];
        return l;
    endfunction

    function automatic void ref_store(input int a, input logic [LW-1:0] l, input int n_words);
        for (int i = 0; i < n_words; i++) ref_mem[a*LS + i] = l[32*i +: 32];
    endfunction

    function automatic void push_exp(input int at, input logic is_wr, input logic chk, input logic [LW-1:0] d);
        exp_t e;
        e.exp_cyc  = at;
        e.is_wr    = is_wr;
        e.chk_data = chk;
        e.data     = d;
        e.tag      = tag_seq;
        tag_seq++;
        sb.push_back(e);
    endfunction

    // Monitor: every gnt must match the oldest expectation in timing and data.
    logic prev_gnt = 1'b0;
    always @(negedge clk) begin
        exp_t e;
        if (rst === 1'b1 && gnt === 1'b1) begin
            check_int("gnt_not_back_to_back", int'(prev_gnt), 0);
            if (sb.size() == 0) begin
                check_int("gnt_was_expected", sb.size(), 1);
            end else begin
                e = sb.pop_front();
                check_int($sformatf("%s%0d_gnt_cycle", e.is_wr ? "wr" : "rd", e.tag), cyc, e.exp_cyc);
                if (e.chk_data)
                    check_line($sformatf("%s%0d_rd_line", e.is_wr ? "wr" : "rd", e.tag), rd_line, e.data);
            end
        end
        prev_gnt = gnt;
    end

    task automatic wait_gnt(input string name);
        int i;
        for (i = 0; i < 80; i++) begin
            @(posedge clk); #1;
            if (gnt) break;
        end
        if (i == 80) check_int({name, "_timeout"}, int'(gnt), 1);
    endtask

    task automatic do_write(input int a, input logic [31:0] base);
        wr_req  = 1'b1;
        addr    = MAL'(a);
        wr_line = mk_line(base);
        push_exp(cyc + GNT_DELAY, 1'b1, rd_known, last_rd);
        ref_store(a, mk_line(base), LS);
        wait_gnt("write");
        wr_req = 1'b0;
        exp_wr_cnt++;
    endtask

    task automatic do_read(input int a);
        rd_req = 1'b1;
        addr   = MAL'(a);
        last_rd = ref_line(a);
        push_exp(cyc + GNT_DELAY, 1'b0, 1'b1, last_rd);
        wait_gnt("read");
        rd_req = 1'b0;
        exp_rd_cnt++;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: cycle %0d, expected finish before it", cyc);
        $fatal(1, "timeout");
    end

    initial begin
        int n;
        // Reset held with a pending read: nothing moves.
        rd_req = 1'b1;
        addr   = 8'h03;
        repeat (3) begin
            @(posedge clk); #1;
            check_int("reset_gnt_low", int'(gnt), 0);
            check_line("reset_rd_line_zero", rd_line, '0);
        end
`ifdef MAIN_MEM_STATS_EN
        check_int("reset_rd_count", int'(rd_count), 0);
        check_int("reset_wr_count", int'(wr_count), 0);
`endif
        rst = 1'b1;
        push_exp(cyc + GNT_DELAY, 1'b0, 1'b0, '0);
        wait_gnt("first_read");
        rd_req = 1'b0;
        exp_rd_cnt++;

        // Neighbour line first, then target line, then read both back.
        do_write(8'h06, 32'hBEEF_0000);
        do_write(8'h05, 32'h0000_1000);
        rd_known = 1'b1;
        do_read(8'h05);
        do_read(8'h06);

        // Simultaneous request: write first, read one cycle after its gnt.
        n = cyc;
        rd_req  = 1'b1;
        wr_req  = 1'b1;
        addr    = 8'h0A;
        wr_line = mk_line(32'hA0A0_0000);
        push_exp(n + GNT_DELAY, 1'b1, 1'b1, last_rd);
        ref_store(8'h0A, mk_line(32'hA0A0_0000), LS);
        last_rd = ref_line(8'h0A);
        push_exp(n + GNT_DELAY + LAT + LS + 1, 1'b0, 1'b1, last_rd);
        wait_gnt("simul_write");
        wr_req = 1'b0;
        exp_wr_cnt++;
        wait_gnt("simul_read");
        rd_req = 1'b0;
        exp_rd_cnt++;

        // Write request dropped three cycles after accept still completes, once.
        n = cyc;
        wr_req  = 1'b1;
        addr    = 8'h20;
        wr_line = mk_line(32'h0000_2000);
        push_exp(n + GNT_DELAY, 1'b1, 1'b1, last_rd);
        ref_store(8'h20, mk_line(32'h0000_2000), LS);
        idle(4);
        wr_req  = 1'b0;
        addr    = 8'h21;
        wr_line = mk_line(32'hDEAD_0000);
        wait_gnt("dropped_write");
        exp_wr_cnt++;
        idle(40);
        check_int("no_extra_op_pending", sb.size(), 0);
        do_read(8'h20);

        // Reset lands while word 3 of a write is being stored.
        do_write(8'h30, 32'h0000_3000);
        n = cyc;
        wr_req  = 1'b1;
        addr    = 8'h30;
        wr_line = mk_line(32'h0000_3300);
        while (cyc < n + 24) idle(1);
        rst    = 1'b0;
        wr_req = 1'b0;
        idle(2);
        check_int("midburst_reset_gnt_low", int'(gnt), 0);
        check_line("midburst_reset_rd_line", rd_line, '0);
        ref_store(8'h30, mk_line(32'h0000_3300), 4);
        last_rd    = '0;
        exp_rd_cnt = 0;
        exp_wr_cnt = 0;
        rst = 1'b1;
        idle(30);
        check_int("midburst_no_gnt_pending", sb.size(), 0);
        do_read(8'h30);

        do_write(8'h40, 32'h4000_0000);
        do_read(8'h40);
        idle(3);
        check_int("scoreboard_drained", sb.size(), 0);
`ifdef MAIN_MEM_STATS_EN
        check_int("stats_rd_count", int'(rd_count), exp_rd_cnt);
        check_int("stats_wr_count", int'(wr_count), exp_wr_cnt);
        rst = 1'b0;
        idle(2);
        check_int("stats_rd_count_reset", int'(rd_count), 0);
        check_int("stats_wr_count_reset", int'(wr_count), 0);
        rst = 1'b1;
`endif
        idle(2);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/main_mem_responder.md
Name: main_mem_responder

Overview:
- Memory-side responder for the data cache's line refill/writeback traffic.
- Accepts a whole-line read or write request and holds it for a fixed access latency.
- Moves the line one word per cycle between the request and an internal word array, then pulses a one-cycle grant.
- Sits below the data cache inside the MEM stage. Its grant lets the cache deassert `miss` and the hazard unit release the pipeline stall.

Parameters:
- LINE_ADDR_LEN, 3, log2 of words per line; LINE_SIZE = 2**LINE_ADDR_LEN.
- MEM_ADDR_LEN, 8, log2 of lines held; array holds 2**(MEM_ADDR_LEN+LINE_ADDR_LEN) 32-bit words.
- LATENCY, 20, idle cycles before the burst starts; must be ≥1.

Ports:
- clk  in  1  core clock.
- rst  in  1  synchronous, active-low reset.
- rd_req  in  1  line read request; level, held by the cache until gnt.
- wr_req  in  1  line write request; level, held until gnt.
- addr  in  MEM_ADDR_LEN  line address.
- wr_line  in  32*LINE_SIZE  line to write; word i at bits [32i+31:32i].
- rd_line  out  32*LINE_SIZE  read line; valid in the gnt cycle, held until the next read completes.
- gnt  out  1  one-cycle completion pulse.

Behaviour:
- Reset (rst=0 at a clk edge):
  - state=IDLE; gnt=0; rd_line=0; counters=0.
  - Array contents are not cleared.
  - Reset mid-operation abandons it. A write in progress may have updated a prefix of the line's words; no gnt is issued.
- FSM has three states: IDLE, WAIT, BURST.
- IDLE:
  - If wr_req=1, latch addr, wr_line and op=WRITE.
  - Else if rd_req=1, latch addr and op=READ.
  - On accept: wait_cnt=LATENCY-1, go to WAIT.
  - Write has priority when both are high. The read stays pending, because the cache keeps rd_req high, and is accepted in the first IDLE cycle after the write's gnt.
- WAIT: decrement wait_cnt; when wait_cnt==0, set word_idx=0 and go to BURST.
- BURST, once per cycle:
  - READ: rd_line word[word_idx] <= array[{addr_latched, word_idx}].
  - WRITE: array[{addr_latched, word_idx}] <= latched word[word_idx].
  - word_idx increments each cycle.
  - On the cycle word_idx==LINE_SIZE-1, go to IDLE and assert gnt=1 on the following cycle only.
- Latency: gnt is high exactly LATENCY+LINE_SIZE cycles after the accepting edge.
- After gnt, one IDLE cycle is spent before a new accept.
- Requests are sampled only in IDLE. A change or deassertion of rd_req, wr_req, addr or wr_line during WAIT/BURST has no effect: the operation completes and gnt still pulses.
- Widths: word address = {addr, word_idx}, MEM_ADDR_LEN+LINE_ADDR_LEN bits, so there is no out-of-range case. wait_cnt is sized clog2(LATENCY)+1.
- gnt is never high for two consecutive cycles.

Optional Feature:
- Macro: MAIN_MEM_STATS_EN.
- Defined: adds outputs rd_count and wr_count, 32 bits each.
  - Each increments by 1 in the cycle its operation's gnt is asserted.
  - Both reset to 0 and wrap at 2**32.
- Undefined: these ports and counters do not exist; all other behaviour is identical.

Decomposition:
- Package main_mem_pkg:
  - state enum {IDLE, WAIT, BURST};
  - op enum {OP_READ, OP_WRITE};
  - default LINE_ADDR_LEN and MEM_ADDR_LEN constants;
  - LINE_SIZE helper.
- Sub-module mem_word_array: single-port synchronous word RAM.
  - Inputs: clk, we, waddr, wdata, raddr.
  - Read is combinational, so a BURST read captures the word the same cycle.
  - Owns the storage array.

Test Plan:
- Reset and idle: rst=0 for 3 cycles with rd_req=1 → gnt=0 and rd_line=0 throughout. After release with LATENCY=20 and LINE_SIZE=8, gnt is high exactly 28 cycles after the first accepting edge.
- Write then read back: wr_req with addr=0x05 and wr_line words 0x1000+i; after gnt, rd_req to addr 0x05 → rd_line words equal 0x1000+i at gnt. Then read addr 0x06 → words at word addresses 48..55 are unchanged.
- Simultaneous request: rd_req=wr_req=1 with addr=0x0A → first gnt is the write. The read is accepted one cycle after gnt and returns the just-written data, with its second gnt 29 cycles after the first.
- Request dropped: wr_req deasserted 3 cycles after accept → gnt still pulses at cycle 28 and the array is updated. No second operation starts.
- Reset mid-burst: rst=0 at BURST word_idx=3 of a write → gnt is never asserted and the FSM is in IDLE. A subsequent read shows words 0..3 new and 4..7 old.
- With MAIN_MEM_STATS_EN, after two writes and three reads → wr_count=2 and rd_count=3. After reset, both are 0.
